// File: rtl/vga_scan_pkg.sv
// Shared constants and types for the VGA scan generator with ordered-dither output.
// The default timing is 640x480@60 stretched to a 48 MHz pixel clock.
package vga_scan_pkg;

    localparam int H_W = 11;
    localparam int V_W = 10;

    localparam int DEF_H_DISPLAY = 1220;
    localparam int DEF_H_FRONT   = 31;
    localparam int DEF_H_SYNC    = 183;
    localparam int DEF_H_BACK    = 92;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DITHER_TRUNC   = 0;
    localparam int DITHER_BAYER8  = 1;
    localparam int DITHER_BAYER84 = 2;

    // One slot of the alignment delay line.
    typedef struct packed {
        logic       active;
        logic       hsync;
        logic       vsync;
        logic [2:0] h_lsb;
        logic [2:0] v_lsb;
        logic       f0;
    } vga_pipe_t;

    // Number of threshold bits the selected Bayer matrix produces.
    function automatic int bayer_bits(input int mode);
        if (mode == DITHER_BAYER8)  return 6;
        if (mode == DITHER_BAYER84) return 5;
        return 0;
    endfunction

endpackage

// File: rtl/vga_scan_dither_bayer.sv
// Combinational per-channel ordered dither from COLOR_W down to OUT_W bits.
// The Bayer threshold is rescaled to the number of bits being dropped, added
// to the colour one bit wider than the input, then saturated.
module bayer_dither
    import vga_scan_pkg::*;
#(
    parameter int COLOR_W     = 6,
    parameter int OUT_W       = 2,
    parameter int DITHER_MODE = DITHER_BAYER84
) (
    input  logic [COLOR_W-1:0] i_c,
    input  logic [2:0]         i_i,
    input  logic [2:0]         i_j,
    input  logic               i_f0,
    output logic [OUT_W-1:0]   o_out
);

    localparam int S      = COLOR_W - OUT_W;
    localparam int B_BITS = bayer_bits(DITHER_MODE);
    localparam int SH_R   = (B_BITS >= S) ? (B_BITS - S) : 0;
    localparam int SH_L   = (B_BITS < S) ? (S - B_BITS) : 0;

    logic [2:0]       w_ip;
    logic [5:0]       w_b;
    logic [S-1:0]     w_t;
    logic [COLOR_W:0] w_sum;
    logic [OUT_W:0]   w_q;

    // Build the threshold, scale it to S bits and saturate the quantised sum.
    always_comb begin
        w_ip = i_i ^ {2'b00, i_f0};
        w_b  = '0;
        case (DITHER_MODE)
            DITHER_BAYER8:  w_b = {i_i[0] ^ i_j[0], i_i[0], i_i[1] ^ i_j[1], i_i[1],
                                   i_i[2] ^ i_j[2], i_i[2]};
            DITHER_BAYER84: w_b = {1'b0, w_ip[0], w_ip[1] ^ i_j[1], w_ip[1],
                                   w_ip[2] ^ i_j[2], w_ip[2]};
            default:        w_b = '0;
        endcase
        w_t   = S'(({{S{1'b0}}, w_b} << SH_L) >> SH_R);
        w_sum = {1'b0, i_c} + {{(COLOR_W + 1 - S){1'b0}}, w_t};
        w_q   = (OUT_W + 1)'(w_sum >> S);
        o_out = w_q[OUT_W] ? {OUT_W{1'b1}} : w_q[OUT_W-1:0];
    end

endmodule

// File: rtl/vga_scan_dither.sv
// VGA scan generator: owns the h/v/frame counters, presents counts and strobes
// to the renderer, and re-aligns syncs/blanking with the returned colour
// through a PIX_LAT-deep delay line before the dithered output register.
module vga_scan_dither
    import vga_scan_pkg::*;
#(
    parameter int   H_DISPLAY   = DEF_H_DISPLAY,
    parameter int   H_FRONT     = DEF_H_FRONT,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BACK      = DEF_H_BACK,
    parameter int   V_DISPLAY   = DEF_V_DISPLAY,
    parameter int   V_FRONT     = DEF_V_FRONT,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BACK      = DEF_V_BACK,
    parameter logic HSYNC_POL   = 1'b0,
    parameter logic VSYNC_POL   = 1'b0,
    parameter int   COLOR_W     = 6,
    parameter int   OUT_W       = 2,
    parameter int   PIX_LAT     = 2,
    parameter int   DITHER_MODE = DITHER_BAYER84,
    parameter int   FRAME_W     = 11
) (
    input  logic               i_clk48,
    input  logic               i_rst,
    input  logic [COLOR_W-1:0] i_r_in,
    input  logic [COLOR_W-1:0] i_g_in,
    input  logic [COLOR_W-1:0] i_b_in,
    output logic [H_W-1:0]     o_h_count,
    output logic [V_W-1:0]     o_v_count,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_display_active,
    output logic               o_line_end,
    output logic               o_frame_start,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic [OUT_W-1:0]   o_r_out,
    output logic [OUT_W-1:0]   o_g_out,
    output logic [OUT_W-1:0]   o_b_out
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [H_W-1:0] L_H_LAST  = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] L_H_DISP  = H_W'(H_DISPLAY);
    localparam logic [H_W-1:0] L_HS_BEG  = H_W'(H_DISPLAY + H_FRONT);
    localparam logic [H_W-1:0] L_HS_END  = H_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [V_W-1:0] L_V_LAST  = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] L_V_DISP  = V_W'(V_DISPLAY);
    localparam logic [V_W-1:0] L_VS_BEG  = V_W'(V_DISPLAY + V_FRONT);
    localparam logic [V_W-1:0] L_VS_END  = V_W'(V_DISPLAY + V_FRONT + V_SYNC);

    localparam vga_pipe_t L_PIPE_RST = vga_pipe_t'({1'b0, ~HSYNC_POL, ~VSYNC_POL, 7'd0});

    generate
        if (OUT_W >= COLOR_W || PIX_LAT < 0 || PIX_LAT > 8 ||
            H_DISPLAY == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
            V_DISPLAY == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0 ||
            H_TOTAL > (1 << H_W) || V_TOTAL > (1 << V_W)) begin : g_bad_param
            $error("vga_scan_dither: illegal parameter combination");
        end
    endgenerate

    logic [H_W-1:0]     r_h_count;
    logic [V_W-1:0]     r_v_count;
    logic [FRAME_W-1:0] r_frame;
    logic               r_hsync;
    logic               r_vsync;
    logic [OUT_W-1:0]   r_r_out;
    logic [OUT_W-1:0]   r_g_out;
    logic [OUT_W-1:0]   r_b_out;

    logic               w_active;
    logic               w_hs_raw;
    logic               w_vs_raw;
    vga_pipe_t          w_cur;
    vga_pipe_t          w_dly;
    logic [OUT_W-1:0]   w_r_dith;
    logic [OUT_W-1:0]   w_g_dith;
    logic [OUT_W-1:0]   w_b_dith;

    // Column/line/frame counters; v and frame advance on the h wrap.
    always_ff @(posedge i_clk48 or posedge i_rst) begin
        if (i_rst) begin
            r_h_count <= '0;
            r_v_count <= '0;
            r_frame   <= '0;
        end else if (r_h_count == L_H_LAST) begin
            r_h_count <= '0;
            if (r_v_count == L_V_LAST) begin
                r_v_count <= '0;
                r_frame   <= r_frame + 1'b1;
            end else begin
                r_v_count <= r_v_count + 1'b1;
            end
        end else begin
            r_h_count <= r_h_count + 1'b1;
        end
    end

    // Undelayed decode of the registered counts.
    always_comb begin
        w_active = (r_h_count < L_H_DISP) && (r_v_count < L_V_DISP);
        w_hs_raw = (r_h_count >= L_HS_BEG && r_h_count < L_HS_END) ? HSYNC_POL : ~HSYNC_POL;
        w_vs_raw = (r_v_count >= L_VS_BEG && r_v_count < L_VS_END) ? VSYNC_POL : ~VSYNC_POL;
        w_cur    = vga_pipe_t'({w_active, w_hs_raw, w_vs_raw,
                                r_h_count[2:0], r_v_count[2:0], r_frame[0]});
    end

    generate
        if (PIX_LAT == 0) begin : g_no_dly
            assign w_dly = w_cur;
        end else begin : g_dly
            vga_pipe_t r_pipe [PIX_LAT];
            // Delay line matching the renderer latency; syncs reset inactive.
            always_ff @(posedge i_clk48 or posedge i_rst) begin
                if (i_rst) begin
                    for (int k = 0; k < PIX_LAT; k++) r_pipe[k] <= L_PIPE_RST;
                end else begin
                    r_pipe[0] <= w_cur;
                    for (int k = 1; k < PIX_LAT; k++) r_pipe[k] <= r_pipe[k-1];
                end
            end
            assign w_dly = r_pipe[PIX_LAT-1];
        end
    endgenerate

    bayer_dither #(.COLOR_W(COLOR_W), .OUT_W(OUT_W), .DITHER_MODE(DITHER_MODE)) u_dith_r (
        .i_c(i_r_in), .i_i(w_dly.h_lsb), .i_j(w_dly.v_lsb), .i_f0(w_dly.f0), .o_out(w_r_dith));
    bayer_dither #(.COLOR_W(COLOR_W), .OUT_W(OUT_W), .DITHER_MODE(DITHER_MODE)) u_dith_g (
        .i_c(i_g_in), .i_i(w_dly.h_lsb), .i_j(w_dly.v_lsb), .i_f0(w_dly.f0), .o_out(w_g_dith));
    bayer_dither #(.COLOR_W(COLOR_W), .OUT_W(OUT_W), .DITHER_MODE(DITHER_MODE)) u_dith_b (
        .i_c(i_b_in), .i_i(w_dly.h_lsb), .i_j(w_dly.v_lsb), .i_f0(w_dly.f0), .o_out(w_b_dith));

    // Output register: aligned syncs and dithered colour, forced to 0 when blanked.
    always_ff @(posedge i_clk48 or posedge i_rst) begin
        if (i_rst) begin
            r_hsync <= ~HSYNC_POL;
            r_vsync <= ~VSYNC_POL;
            r_r_out <= '0;
            r_g_out <= '0;
            r_b_out <= '0;
        end else begin
            r_hsync <= w_dly.hsync;
            r_vsync <= w_dly.vsync;
            r_r_out <= w_dly.active ? w_r_dith : '0;
            r_g_out <= w_dly.active ? w_g_dith : '0;
            r_b_out <= w_dly.active ? w_b_dith : '0;
        end
    end

    // Strobes are held low while reset is asserted even though the counts read (0,0).
    assign o_line_end       = ~i_rst & (r_h_count == L_H_DISP);
    assign o_frame_start    = ~i_rst & (r_h_count == '0) & (r_v_count == '0);
    assign o_display_active = w_active;
    assign o_h_count        = r_h_count;
    assign o_v_count        = r_v_count;
    assign o_frame          = r_frame;
    assign o_hsync          = r_hsync;
    assign o_vsync          = r_vsync;
    assign o_r_out          = r_r_out;
    assign o_g_out          = r_g_out;
    assign o_b_out          = r_b_out;

endmodule

// File: tb/tb_vga_scan_dither.sv
// Directed bench for vga_scan_dither using a shrunken 24x20 raster.
// DUT A: 8x4 per-frame Bayer, PIX_LAT=2. DUT B: 8x8 Bayer, PIX_LAT=0.
module tb_vga_scan_dither;

    localparam int HD = 16, HF = 2, HS = 3, HB = 3, HT = HD + HF + HS + HB;
    localparam int VD = 16, VF = 1, VS = 2, VB = 1, VT = VD + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [5:0]  a_r, a_g, a_b, b_r, b_g, b_b;
    logic [10:0] a_h, b_h;
    logic [9:0]  a_v, b_v;
    logic [1:0]  a_f, b_f;
    logic        a_act, a_le, a_fs, a_hs, a_vs;
    logic        b_act, b_le, b_fs, b_hs, b_vs;
    logic [1:0]  a_ro, a_go, a_bo, b_ro, b_go, b_bo;

    int n_cmp = 0;
    int n_bad = 0;
    bit cap_en = 1'b1;

    logic [1:0] g_a  [2][8][8];
    logic [1:0] g_br [8][8];
    logic [1:0] g_bg [8][8];
    logic [1:0] g_bb [8][8];
    int c3, c2, c0, c3b, dif;

    always #5 clk = ~clk;

    vga_scan_dither #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_W(6), .OUT_W(2),
        .PIX_LAT(LAT_A), .DITHER_MODE(2), .FRAME_W(2)
    ) u_dut_a (
        .i_clk48(clk), .i_rst(rst), .i_r_in(a_r), .i_g_in(a_g), .i_b_in(a_b),
        .o_h_count(a_h), .o_v_count(a_v), .o_frame(a_f), .o_display_active(a_act),
        .o_line_end(a_le), .o_frame_start(a_fs), .o_hsync(a_hs), .o_vsync(a_vs),
        .o_r_out(a_ro), .o_g_out(a_go), .o_b_out(a_bo)
    );

    vga_scan_dither #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_W(6), .OUT_W(2),
        .PIX_LAT(LAT_B), .DITHER_MODE(1), .FRAME_W(2)
    ) u_dut_b (
        .i_clk48(clk), .i_rst(rst), .i_r_in(b_r), .i_g_in(b_g), .i_b_in(b_b),
        .o_h_count(b_h), .o_v_count(b_v), .o_frame(b_f), .o_display_active(b_act),
        .o_line_end(b_le), .o_frame_start(b_fs), .o_hsync(b_hs), .o_vsync(b_vs),
        .o_r_out(b_ro), .o_g_out(b_go), .o_b_out(b_bo)
    );

    function automatic int eh(input int n); return n % HT; endfunction
    function automatic int ev(input int n); return (n / HT) % VT; endfunction
    function automatic int ef(input int n); return (n / FT) % 4; endfunction
    function automatic logic eact(input int n); return (eh(n) < HD) && (ev(n) < VD); endfunction
    function automatic logic ehs(input int n);
        return !(eh(n) >= HD + HF && eh(n) < HD + HF + HS);
    endfunction
    function automatic logic evs(input int n);
        return !(ev(n) >= VD + VF && ev(n) < VD + VF + VS);
    endfunction
    function automatic logic ohs(input int n, input int lat);
        if (n < lat + 1) return 1'b1;
        return ehs(n - lat - 1);
    endfunction
    function automatic logic ovs(input int n, input int lat);
        if (n < lat + 1) return 1'b1;
        return evs(n - lat - 1);
    endfunction
    function automatic logic oblank(input int n, input int lat);
        if (n < lat + 1) return 1'b1;
        return !eact(n - lat - 1);
    endfunction

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @%0d: observed %0d expected %0d", tag, idx, obs, exp);
        end
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_a_h"}, 0, a_h, 0);
        chk({tag, "_a_v"}, 0, a_v, 0);
        chk({tag, "_a_f"}, 0, a_f, 0);
        chk({tag, "_a_le"}, 0, a_le, 0);
        chk({tag, "_a_fs"}, 0, a_fs, 0);
        chk({tag, "_a_hs"}, 0, a_hs, 1);
        chk({tag, "_a_vs"}, 0, a_vs, 1);
        chk({tag, "_a_rgb"}, 0, {a_ro, a_go, a_bo}, 0);
        chk({tag, "_b_h"}, 0, b_h, 0);
        chk({tag, "_b_fs"}, 0, b_fs, 0);
        chk({tag, "_b_hs"}, 0, b_hs, 1);
        chk({tag, "_b_rgb"}, 0, {b_ro, b_go, b_bo}, 0);
    endtask

    // Per-cycle checks of counts, strobes, aligned syncs and blanking, plus capture.
    task automatic step(input int n);
        int p;
        chk("a_h", n, a_h, eh(n));
        chk("a_v", n, a_v, ev(n));
        chk("a_frame", n, a_f, ef(n));
        chk("a_active", n, a_act, eact(n));
        chk("a_line_end", n, a_le, eh(n) == HD);
        chk("a_frame_start", n, a_fs, eh(n) == 0 && ev(n) == 0);
        chk("a_hsync", n, a_hs, ohs(n, LAT_A));
        chk("a_vsync", n, a_vs, ovs(n, LAT_A));
        chk("b_h", n, b_h, eh(n));
        chk("b_v", n, b_v, ev(n));
        chk("b_frame", n, b_f, ef(n));
        chk("b_active", n, b_act, eact(n));
        chk("b_line_end", n, b_le, eh(n) == HD);
        chk("b_frame_start", n, b_fs, eh(n) == 0 && ev(n) == 0);
        chk("b_hsync", n, b_hs, ohs(n, LAT_B));
        chk("b_vsync", n, b_vs, ovs(n, LAT_B));
        if (oblank(n, LAT_A)) chk("a_blank", n, {a_ro, a_go, a_bo}, 0);
        if (oblank(n, LAT_B)) chk("b_blank", n, {b_ro, b_go, b_bo}, 0);
        if (cap_en && n >= LAT_A + 1) begin
            p = n - LAT_A - 1;
            if (eh(p) < 8 && ev(p) < 8 && ef(p) < 2) g_a[ef(p)][ev(p)][eh(p)] = a_ro;
        end
        if (cap_en && n >= LAT_B + 1) begin
            p = n - LAT_B - 1;
            if (eh(p) < 8 && ev(p) < 8 && ef(p) == 0) begin
                g_br[ev(p)][eh(p)] = b_ro;
                g_bg[ev(p)][eh(p)] = b_go;
                g_bb[ev(p)][eh(p)] = b_bo;
            end
        end
    endtask

    initial begin
        a_r = 6'd36; a_g = 6'd36; a_b = 6'd36;
        b_r = 6'd40; b_g = 6'd0;  b_b = 6'd63;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        reset_chk("por");

        @(negedge clk);
        rst = 1'b0;
        #1;
        step(0);
        for (int n = 1; n <= 2050; n++) begin
            @(negedge clk);
            step(n);
            if (n == 955) begin
                a_r = 6'd0; a_g = 6'd0; a_b = 6'd0;
            end
            if (n == 964) begin
                cap_en = 1'b0;
                c3 = 0; c2 = 0; c0 = 0; c3b = 0;
                for (int y = 0; y < 8; y++)
                    for (int x = 0; x < 8; x++) begin
                        if (g_br[y][x] === 2'd3) c3++;
                        if (g_br[y][x] === 2'd2) c2++;
                        if (g_bg[y][x] === 2'd0) c0++;
                        if (g_bb[y][x] === 2'd3) c3b++;
                    end
                chk("m1_c40_threes", n, c3, 32);
                chk("m1_c40_twos", n, c2, 32);
                chk("m1_c0_zeros", n, c0, 64);
                chk("m1_c63_threes", n, c3b, 64);
                c3 = 0; c2 = 0; c3b = 0; dif = 0;
                for (int y = 0; y < 8; y++)
                    for (int x = 0; x < 8; x++) begin
                        if (g_a[0][y][x] === 2'd3) c3++;
                        if (g_a[0][y][x] === 2'd2) c2++;
                        if (g_a[1][y][x] === 2'd3) c3b++;
                        if (g_a[0][y][x] !== g_a[1][y][x]) dif++;
                    end
                chk("m2_even_threes", n, c3, 16);
                chk("m2_even_twos", n, c2, 48);
                chk("m2_odd_threes", n, c3b, 16);
                chk("m2_two_frame_threes", n, c3 + c3b, 32);
                chk("m2_frames_differ", n, dif, 32);
                chk("m2_even_px_1_2", n, g_a[0][2][1], 3);
                chk("m2_odd_px_1_2", n, g_a[1][2][1], 2);
            end
            if (n >= 960 && n < 960 + HT) chk("lat_pulse_r", n, a_ro, (n == 968) ? 3 : 0);
            if (n == 967) a_r = 6'd63;
            if (n == 968) a_r = 6'd0;
        end

        rst = 1'b1;
        #1;
        reset_chk("mid");
        repeat (3) begin
            @(negedge clk);
            chk("mid_hold_a_h", 0, a_h, 0);
            chk("mid_hold_a_rgb", 0, {a_ro, a_go, a_bo}, 0);
        end
        rst = 1'b0;
        #1;
        step(0);
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk);
            step(n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
